// File: rtl/clock_divider_gen_if.sv
// Control and observation bundle for the programmable clock divider.
// The master side drives enable/period programming; the slave produces the clock.
interface clock_divider_gen_if #(
  parameter int CW = 16
);
  logic          enable;
  logic          period_load;
  logic [CW-1:0] period_in;
  logic          div_clk;
  logic          rise_pulse;
  logic          fall_pulse;
  logic [31:0]   cycle_count;
  logic [CW-1:0] active_period;

  modport master (
    output enable,
    output period_load,
    output period_in,
    input  div_clk,
    input  rise_pulse,
    input  fall_pulse,
    input  cycle_count,
    input  active_period
  );

  modport slave (
    input  enable,
    input  period_load,
    input  period_in,
    output div_clk,
    output rise_pulse,
    output fall_pulse,
    output cycle_count,
    output active_period
  );
endinterface

// File: rtl/clock_divider_gen.sv
// Programmable clock divider with rise/fall strobes and period counter.
// Period changes are staged in a pending register and applied at wrap.
module clock_divider_gen #(
  parameter int PERIOD = 10,
  parameter int CW     = 16
) (
  input logic               clk,
  input logic               reset,
  clock_divider_gen_if.slave bus
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] pending;
  logic [CW-1:0] period;
  logic [CW-1:0] new_cnt;
  logic [CW-1:0] next_pending;
  logic [CW-1:0] next_period;
  logic [CW-1:0] half;
  logic [31:0]   count;
  logic          div_q;
  logic          rise_q;
  logic          fall_q;
  logic          wrap;
  logic          load_ok;

  always_comb begin
    load_ok      = bus.period_load && (bus.period_in >= CW'(2));
    next_pending = load_ok ? bus.period_in : pending;
    wrap         = (cnt == period - CW'(1));
    new_cnt      = wrap ? '0 : cnt + CW'(1);
    // a load landing on the wrap edge bypasses straight into use
    next_period  = wrap ? next_pending : period;
    half         = next_period - (next_period >> 1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= CW'(PERIOD - 1);
      pending <= CW'(PERIOD);
      period  <= CW'(PERIOD);
      div_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count   <= '0;
    end else begin
      pending <= next_pending;
      if (bus.enable) begin
        cnt    <= new_cnt;
        period <= next_period;
        div_q  <= (new_cnt < half);
        rise_q <= (new_cnt == '0);
        fall_q <= (new_cnt == half);
        if (new_cnt == '0)
          count <= count + 32'd1;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end
    end
  end

  assign bus.div_clk       = div_q;
  assign bus.rise_pulse    = rise_q;
  assign bus.fall_pulse    = fall_q;
  assign bus.cycle_count   = count;
  assign bus.active_period = period;

endmodule

// File: tb/tb_clock_divider_gen.sv
// Directed bench for clock_divider_gen with a cycle-level scoreboard.
// Expected outputs are queued as each edge is driven, then checked after it.
module tb_clock_divider_gen;

  localparam int CW = 16;

  typedef struct {
    logic        div;
    logic        rise;
    logic        fall;
    logic [31:0] cc;
    logic [15:0] ap;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  int m_cnt, m_p, m_pend, m_cc;
  logic m_div, m_rise, m_fall;

  clock_divider_gen_if #(.CW(CW)) bus ();

  clock_divider_gen #(.PERIOD(10), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Behavioural reference of one clk edge, in spec terms.
  task automatic model(input logic rst, input logic en,
                       input logic ld, input int pin);
    int h;
    if (!rst) begin
      m_p = 10; m_pend = 10; m_cnt = 9; m_cc = 0;
      m_div = 0; m_rise = 0; m_fall = 0;
    end else begin
      if (ld && pin >= 2) m_pend = pin;
      if (en) begin
        if (m_cnt == m_p - 1) begin
          m_cnt = 0;
          m_p = m_pend;
        end else begin
          m_cnt = m_cnt + 1;
        end
        h = m_p - m_p / 2;
        m_div = (m_cnt < h);
        m_rise = (m_cnt == 0);
        m_fall = (m_cnt == h);
        if (m_rise) m_cc = m_cc + 1;
      end else begin
        m_rise = 0;
        m_fall = 0;
      end
    end
  endtask

  task automatic step(input logic rst, input logic en,
                      input logic ld, input int pin);
    exp_t e;
    reset = rst;
    bus.enable = en;
    bus.period_load = ld;
    bus.period_in = CW'(pin);
    model(rst, en, ld, pin);
    e.div = m_div; e.rise = m_rise; e.fall = m_fall;
    e.cc = m_cc; e.ap = 16'(m_p);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("div_clk", 32'(bus.div_clk), 32'(e.div));
      chk("rise_pulse", 32'(bus.rise_pulse), 32'(e.rise));
      chk("fall_pulse", 32'(bus.fall_pulse), 32'(e.fall));
      chk("cycle_count", bus.cycle_count, e.cc);
      chk("active_period", 32'(bus.active_period), 32'(e.ap));
      chk("pulse_excl", 32'(bus.rise_pulse & bus.fall_pulse), 32'd0);
    end
  endtask

  // Advance until the next enabled edge will be a wrap edge.
  task automatic to_prewrap();
    int n = 0;
    while (m_cnt != m_p - 1 && n < 100) begin
      step(1, 1, 0, 0);
      n++;
    end
    if (n >= 100) chk("prewrap_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int exp4[4];
    int exp3[3];
    int exp6[6];
    exp4 = '{1, 0, 0, 1};
    exp3 = '{1, 0, 1};
    exp6 = '{1, 1, 0, 0, 0, 1};

    reset = 1'b0;
    bus.enable = 1'b1;
    bus.period_load = 1'b0;
    bus.period_in = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("rst_div", 32'(bus.div_clk), 32'd0);
      chk("rst_cc", bus.cycle_count, 32'd0);
      chk("rst_ap", 32'(bus.active_period), 32'd10);
    end

    step(1, 1, 0, 0);
    chk("first_div", 32'(bus.div_clk), 32'd1);
    chk("first_rise", 32'(bus.rise_pulse), 32'd1);
    chk("first_cc", bus.cycle_count, 32'd1);
    for (int i = 1; i < 41; i++) begin
      step(1, 1, 0, 0);
      if (i >= 1 && i <= 4)
        chk("p10_high", 32'(bus.div_clk), 32'd1);
      if (i >= 5 && i <= 9)
        chk("p10_low", 32'(bus.div_clk), 32'd0);
    end
    chk("cc_after_41", bus.cycle_count, 32'd5);

    // freeze at phase 3
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("frz_div", 32'(bus.div_clk), 32'd1);
      chk("frz_cc", bus.cycle_count, 32'd5);
      chk("frz_rise", 32'(bus.rise_pulse), 32'd0);
    end
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    chk("resume_no_wrap", bus.cycle_count, 32'd5);
    step(1, 1, 0, 0);
    chk("resume_wrap", bus.cycle_count, 32'd6);

    // load 4 mid-period
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 4);
    chk("ld4_deferred", 32'(bus.active_period), 32'd10);
    to_prewrap();
    chk("ld4_still10", 32'(bus.active_period), 32'd10);
    step(1, 1, 0, 0);
    chk("ld4_active", 32'(bus.active_period), 32'd4);
    chk("ld4_rise", 32'(bus.rise_pulse), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      chk("p4_wave", 32'(bus.div_clk), 32'(exp4[i]));
    end

    // illegal loads ignored
    step(1, 1, 1, 1);
    step(1, 1, 1, 0);
    to_prewrap();
    step(1, 1, 0, 0);
    chk("illegal_ignored", 32'(bus.active_period), 32'd4);

    step(1, 1, 1, 3);
    to_prewrap();
    step(1, 1, 0, 0);
    chk("ld3_active", 32'(bus.active_period), 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      chk("p3_wave", 32'(bus.div_clk), 32'(exp3[i]));
    end

    // load exactly on wrap edge
    to_prewrap();
    step(1, 1, 1, 6);
    chk("bypass_active", 32'(bus.active_period), 32'd6);
    chk("bypass_div", 32'(bus.div_clk), 32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      chk("p6_wave", 32'(bus.div_clk), 32'(exp6[i]));
    end

    // reset mid-high with P=6
    step(1, 1, 0, 0);
    chk("pre_rst_high", 32'(bus.div_clk), 32'd1);
    step(0, 1, 0, 0);
    chk("midrst_div", 32'(bus.div_clk), 32'd0);
    chk("midrst_cc", bus.cycle_count, 32'd0);
    chk("midrst_ap", 32'(bus.active_period), 32'd10);
    step(1, 1, 0, 0);
    chk("post_rst_rise", 32'(bus.rise_pulse), 32'd1);
    chk("post_rst_cc", bus.cycle_count, 32'd1);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    chk("post_rst_p10", bus.cycle_count, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
